exe_unit: RTL and testbench



---
 rtl/exe_unit.sv | 96 +++++++++
 tb/tb_exe_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/exe_unit.sv
`default_nettype none
// ============================================================================
// Module   : exe_unit
// Brief    : 10-bit execute stage. It contains a 16-entry register file and an
//            8-op combinational ALU, and registers the status flags.
// Revision : 1.0 - initial release
// ============================================================================
module exe_unit (
   input  logic              i_clk,
   input  logic              i_rsn,
   input  logic [2:0]        i_oper,
   input  logic [3:0]        i_reg0,
   input  logic [3:0]        i_reg1,
   input  logic [3:0]        i_reg2,
   input  logic signed [9:0] i_data2,
   input  logic signed [9:0] i_data,
   input  logic              i_imm,
   output logic [3:0]        o_flag,
   output logic signed [9:0] o_data
);

   localparam logic [2:0] c_op_add  = 3'd0;
   localparam logic [2:0] c_op_sub  = 3'd1;
   localparam logic [2:0] c_op_max  = 3'd2;
   localparam logic [2:0] c_op_min  = 3'd3;
   localparam logic [2:0] c_op_and  = 3'd4;
   localparam logic [2:0] c_op_or   = 3'd5;
   localparam logic [2:0] c_op_xor  = 3'd6;
   localparam logic [2:0] c_op_xnor = 3'd7;

   logic signed [9:0] r_regs [16];
   logic [3:0]        r_flag;

   logic signed [9:0] w_a;
   logic signed [9:0] w_b;
   logic signed [9:0] w_res;
   logic [10:0]       w_sum;
   logic [10:0]       w_diff;
   logic              w_c;
   logic              w_v;
   logic [3:0]        w_flag;

   // Entry 0 is never written, so it stays 0 after reset; the mux makes that explicit.
   assign w_a = (i_reg0 == 4'd0) ? 10'sd0 : r_regs[i_reg0];
   assign w_b = i_imm ? i_data : ((i_reg1 == 4'd0) ? 10'sd0 : r_regs[i_reg1]);

   assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
   // Bit 10 of the zero-extended difference is the unsigned borrow (A < B).
   assign w_diff = {1'b0, w_a} - {1'b0, w_b};

   always_comb begin
      w_res = w_sum[9:0];
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (i_oper)
         c_op_add: begin
            w_res = w_sum[9:0];
            w_c   = w_sum[10];
            w_v   = (w_a[9] == w_b[9]) && (w_sum[9] != w_a[9]);
         end
         c_op_sub: begin
            w_res = w_diff[9:0];
            w_c   = w_diff[10];
            w_v   = (w_a[9] != w_b[9]) && (w_diff[9] != w_a[9]);
         end
         c_op_max:  w_res = (w_a > w_b) ? w_a : w_b;
         c_op_min:  w_res = (w_a < w_b) ? w_a : w_b;
         c_op_and:  w_res = w_a & w_b;
         c_op_or:   w_res = w_a | w_b;
         c_op_xor:  w_res = w_a ^ w_b;
         c_op_xnor: w_res = ~(w_a ^ w_b);
         default:   w_res = w_sum[9:0];
      endcase
   end

   assign w_flag = {w_v, w_c, w_res[9], (w_res == 10'sd0)};

   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         for (int i = 0; i < 16; i++) begin
            r_regs[i] <= '0;
         end
         r_flag <= '0;
      end else begin
         if (i_reg2 != 4'd0) begin
            r_regs[i_reg2] <= i_data2;
         end
         r_flag <= w_flag;
      end
   end

   assign o_data = w_res;
   assign o_flag = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_exe_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_unit
// Brief    : Directed self-checking bench for exe_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_unit;

   logic              i_clk;
   logic              i_rsn;
   logic [2:0]        i_oper;
   logic [3:0]        i_reg0;
   logic [3:0]        i_reg1;
   logic [3:0]        i_reg2;
   logic signed [9:0] i_data2;
   logic signed [9:0] i_data;
   logic              i_imm;
   logic [3:0]        o_flag;
   logic signed [9:0] o_data;

   int r_total = 0;
   int r_bad   = 0;

   exe_unit u_dut (
      .i_clk   (i_clk),
      .i_rsn   (i_rsn),
      .i_oper  (i_oper),
      .i_reg0  (i_reg0),
      .i_reg1  (i_reg1),
      .i_reg2  (i_reg2),
      .i_data2 (i_data2),
      .i_data  (i_data),
      .i_imm   (i_imm),
      .o_flag  (o_flag),
      .o_data  (o_data)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      r_total++;
      if (got !== exp) begin
         r_bad++;
         $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, $signed(got), got,
                  $signed(exp), exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic imm, input logic signed [9:0] d);
      i_oper = op;
      i_reg0 = a;
      i_reg1 = b;
      i_imm  = imm;
      i_data = d;
      #1;
   endtask

   logic signed [9:0] r_exp_data [8];
   logic [3:0]        r_exp_flag [8];

   initial begin
      // Expected results for pairs (Rk, Rk+1), Rk = 24*k, op = k-1
      r_exp_data[0] = 10'sd72;   r_exp_flag[0] = 4'b0000;
      r_exp_data[1] = -10'sd24;  r_exp_flag[1] = 4'b0110;
      r_exp_data[2] = 10'sd96;   r_exp_flag[2] = 4'b0000;
      r_exp_data[3] = 10'sd96;   r_exp_flag[3] = 4'b0000;
      r_exp_data[4] = 10'sd16;   r_exp_flag[4] = 4'b0000;
      r_exp_data[5] = 10'sd184;  r_exp_flag[5] = 4'b0000;
      r_exp_data[6] = 10'sd104;  r_exp_flag[6] = 4'b0000;
      r_exp_data[7] = -10'sd25;  r_exp_flag[7] = 4'b0010;

      i_rsn = 1'b0; i_oper = 3'd0; i_reg0 = 4'd0; i_reg1 = 4'd0; i_reg2 = 4'd0;
      i_data2 = 10'sd0; i_data = 10'sd0; i_imm = 1'b0;
      #2;
      check("rst_data", 16'(o_data), 16'(10'sd0));
      check("rst_flag", 16'(o_flag), 16'd0);
      drive(3'd0, 4'd0, 4'd0, 1'b1, 10'sd5);
      check("rst_imm_add", 16'(o_data), 16'(10'sd5));
      // Writes are ignored during reset
      i_reg2 = 4'd2; i_data2 = 10'sd55;
      tick();
      i_reg2 = 4'd0;
      drive(3'd0, 4'd2, 4'd0, 1'b0, 10'sd0);
      check("rst_nowrite", 16'(o_data), 16'(10'sd0));
      #2;
      i_rsn = 1'b1;

      // Fill R1..R9 with 24*k
      for (int k = 1; k <= 9; k++) begin
         i_reg2  = 4'(k);
         i_data2 = 10'(24 * k);
         tick();
      end
      i_reg2 = 4'd0; i_data2 = 10'sd99;
      tick();
      drive(3'd0, 4'd0, 4'd0, 1'b0, 10'sd0);
      check("r0_stays0", 16'(o_data), 16'(10'sd0));
      // Write through R0 was attempted: R0 must not have become 99
      i_reg2 = 4'd0;

      // ALU sweep
      for (int k = 1; k <= 8; k++) begin
         drive(3'(k - 1), 4'(k), 4'(k + 1), 1'b0, 10'sd0);
         check($sformatf("sweep_data%0d", k - 1), 16'(o_data), 16'(r_exp_data[k - 1]));
         tick();
         check($sformatf("sweep_flag%0d", k - 1), 16'(o_flag), 16'(r_exp_flag[k - 1]));
      end

      // Write-back then overflow
      drive(3'd0, 4'd7, 4'd8, 1'b0, 10'sd0);
      check("add78", 16'(o_data), 16'(10'sd360));
      i_reg2 = 4'd9; i_data2 = o_data;
      tick();
      i_reg2 = 4'd0;
      drive(3'd0, 4'd8, 4'd9, 1'b0, 10'sd0);
      check("add89_wrap", 16'(o_data), 16'(-10'sd472));
      tick();
      check("add89_flag", 16'(o_flag), 16'(4'b1010));

      // Read-modify-write
      drive(3'd1, 4'd4, 4'd1, 1'b0, 10'sd0);
      check("rmw_before", 16'(o_data), 16'(10'sd72));
      i_reg2 = 4'd4; i_data2 = o_data;
      tick();
      i_reg2 = 4'd0;
      #1;
      check("rmw_after", 16'(o_data), 16'(10'sd48));

      // Immediate operand, then zero result
      drive(3'd0, 4'd0, 4'd0, 1'b1, 10'sd27);
      check("imm_add", 16'(o_data), 16'(10'sd27));
      drive(3'd0, 4'd0, 4'd0, 1'b0, 10'sd27);
      check("zero_data", 16'(o_data), 16'(10'sd0));
      tick();
      check("zero_flag", 16'(o_flag), 16'(4'b0001));

      // Produce a nonzero flag, then assert reset between edges
      drive(3'd1, 4'd1, 4'd2, 1'b0, 10'sd0);
      tick();
      check("pre_rst_flag", 16'(o_flag), 16'(4'b0110));
      drive(3'd0, 4'd7, 4'd0, 1'b0, 10'sd0);
      check("pre_rst_r7", 16'(o_data), 16'(10'sd168));
      #1;
      i_reg2 = 4'd3; i_data2 = 10'sd77;
      i_rsn = 1'b0;
      #1;
      check("async_rst_data", 16'(o_data), 16'(10'sd0));
      check("async_rst_flag", 16'(o_flag), 16'd0);
      tick();
      i_reg2 = 4'd0;
      drive(3'd0, 4'd3, 4'd0, 1'b0, 10'sd0);
      check("rst_write_ignored", 16'(o_data), 16'(10'sd0));
      #2;
      i_rsn = 1'b1;
      drive(3'd1, 4'd0, 4'd0, 1'b1, 10'sd1);
      check("post_rst_sub", 16'(o_data), 16'(-10'sd1));
      tick();
      check("post_rst_flag", 16'(o_flag), 16'(4'b0110));

      $display("test done: total=%0d bad=%0d", r_total, r_bad);
      $finish;
   end

endmodule
`default_nettype wire
